// File: rtl/data_bus_pkg.sv
// Shared types and defaults for the core-LSU to peripheral data bus bridge.
package data_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, RESP} bridge_state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Per-phase wait counter; expired flags the last allowed cycle of a wait phase.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CW'(1);
  end

  // Count is held at zero outside wait phases and LAST >= 1, so no gating needed.
  assign expired = (count == LAST);

endmodule

// File: rtl/data_bus_bridge.sv
// Single-outstanding core-LSU to peripheral bridge with per-phase timeout.
// Optional error log (err_addr/err_valid) enabled by defining BUS_ERR_LOG_EN.
module data_bus_bridge
  import data_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        periph_req,
  output logic        periph_we,
  output logic [3:0]  periph_be,
  output logic [31:0] periph_addr,
  output logic [31:0] periph_wdata,
  input  logic        periph_gnt,
  input  logic        periph_rvalid,
  input  logic [31:0] periph_rdata,
  output logic [31:0] err_addr,
  output logic        err_valid,
  input  logic        err_clr
);

  bridge_state_t state, state_d;
  bus_req_t      req_q;
  logic          periph_req_d;
  logic          ld_req, resp_set, resp_err;
  logic          cnt_clear, cnt_en, expired;

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d      = state;
    periph_req_d = periph_req;
    ld_req       = 1'b0;
    resp_set     = 1'b0;
    resp_err     = 1'b0;
    cnt_clear    = 1'b1;
    cnt_en       = 1'b0;
    case (state)
      IDLE: begin
        if (core_req) begin
          ld_req       = 1'b1;
          periph_req_d = 1'b1;
          state_d      = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b1;
        // Grant in the expiry cycle still counts as a normal handoff.
        if (periph_gnt) begin
          periph_req_d = 1'b0;
          cnt_clear    = 1'b1;
          state_d      = WAIT_RVALID;
        end else if (expired) begin
          periph_req_d = 1'b0;
          cnt_clear    = 1'b1;
          resp_set     = 1'b1;
          resp_err     = 1'b1;
          state_d      = RESP;
        end
      end
      WAIT_RVALID: begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b1;
        if (periph_rvalid) begin
          cnt_clear = 1'b1;
          resp_set  = 1'b1;
          state_d   = RESP;
        end else if (expired) begin
          cnt_clear = 1'b1;
          resp_set  = 1'b1;
          resp_err  = 1'b1;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q       <= '0;
      periph_req  <= 1'b0;
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      core_err    <= 1'b0;
    end else begin
      periph_req  <= periph_req_d;
      core_rvalid <= resp_set;
      if (ld_req) begin
        req_q.we    <= core_we;
        req_q.be    <= core_be;
        req_q.addr  <= core_addr;
        req_q.wdata <= core_wdata;
      end
      if (resp_set) begin
        core_err   <= resp_err;
        core_rdata <= resp_err ? ERR_RDATA : periph_rdata;
      end
    end
  end

  // Gated with reset so every output reads 0 while reset is asserted.
  assign core_gnt     = rst && (state == IDLE);
  assign periph_we    = req_q.we;
  assign periph_be    = req_q.be;
  assign periph_addr  = req_q.addr;
  assign periph_wdata = req_q.wdata;

`ifdef BUS_ERR_LOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_addr  <= '0;
      err_valid <= 1'b0;
    end else if (resp_set && resp_err) begin
      err_addr  <= req_q.addr;
      err_valid <= 1'b1;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_addr       = '0;
  assign err_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed self-checking bench for data_bus_bridge (TIMEOUT_CYCLES=16).
module tb_data_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        periph_req, periph_we;
  logic [3:0]  periph_be;
  logic [31:0] periph_addr, periph_wdata;
  logic        periph_gnt, periph_rvalid;
  logic [31:0] periph_rdata;
  logic [31:0] err_addr;
  logic        err_valid, err_clr;

  int checks = 0;
  int errors = 0;

  data_bus_bridge #(.TIMEOUT_CYCLES(16), .ERR_RDATA(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_err(core_err),
    .periph_req(periph_req), .periph_we(periph_we), .periph_be(periph_be),
    .periph_addr(periph_addr), .periph_wdata(periph_wdata),
    .periph_gnt(periph_gnt), .periph_rvalid(periph_rvalid),
    .periph_rdata(periph_rdata),
    .err_addr(err_addr), .err_valid(err_valid), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(core_gnt),    32'h0);
    chk({tag, "_rvalid"}, 32'(core_rvalid), 32'h0);
    chk({tag, "_rdata"},  core_rdata,       32'h0);
    chk({tag, "_err"},    32'(core_err),    32'h0);
    chk({tag, "_preq"},   32'(periph_req),  32'h0);
    chk({tag, "_pwe"},    32'(periph_we),   32'h0);
    chk({tag, "_paddr"},  periph_addr,      32'h0);
    chk({tag, "_evalid"}, 32'(err_valid),   32'h0);
    chk({tag, "_eaddr"},  err_addr,         32'h0);
  endtask

  initial begin
    rst = 1'b0; core_req = 1'b0; core_we = 1'b0; core_be = 4'h0;
    core_addr = '0; core_wdata = '0; periph_gnt = 1'b0; periph_rvalid = 1'b0;
    periph_rdata = '0; err_clr = 1'b0;
    #1;
    chk_all_zero("reset");
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("idle_gnt", 32'(core_gnt), 32'h1);

    // T1: zero-wait read, core_req@0 -> core_rvalid@3
    core_req = 1'b1; core_we = 1'b0; core_be = 4'hF; core_addr = 32'h0000_0010;
    cyc();
    core_req = 1'b0;
    chk("t1_preq",  32'(periph_req), 32'h1);
    chk("t1_paddr", periph_addr,     32'h0000_0010);
    chk("t1_gnt",   32'(core_gnt),   32'h0);
    periph_gnt = 1'b1;
    cyc();
    periph_gnt = 1'b0;
    chk("t1_preq_drop", 32'(periph_req), 32'h0);
    periph_rvalid = 1'b1; periph_rdata = 32'hCAFE_BABE;
    cyc();
    periph_rvalid = 1'b0;
    chk("t1_rvalid", 32'(core_rvalid), 32'h1);
    chk("t1_rdata",  core_rdata,       32'hCAFE_BABE);
    chk("t1_err",    32'(core_err),    32'h0);
    cyc();
    chk("t1_pulse", 32'(core_rvalid), 32'h0);
    chk("t1_idle",  32'(core_gnt),    32'h1);

    // T2: unmapped address, no grant ever
    core_req = 1'b1; core_addr = 32'hF000_0000;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      core_req = 1'b0;
      chk("t2_preq_hold", 32'(periph_req), 32'h1);
    end
    cyc();
    chk("t2_preq_drop", 32'(periph_req),  32'h0);
    chk("t2_rvalid",    32'(core_rvalid), 32'h1);
    chk("t2_err",       32'(core_err),    32'h1);
    chk("t2_rdata",     core_rdata,       32'h0);
`ifdef BUS_ERR_LOG_EN
    chk("t2_eaddr",  err_addr,        32'hF000_0000);
    chk("t2_evalid", 32'(err_valid),  32'h1);
`endif
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t2_pulse",  32'(core_rvalid), 32'h0);
    chk("t2_evalid_clr", 32'(err_valid), 32'h0);
`ifndef BUS_ERR_LOG_EN
    chk("t2_eaddr_off", err_addr, 32'h0);
`endif

    // T3: granted, then no rvalid -> timeout in WAIT_RVALID
    core_req = 1'b1; core_addr = 32'h0000_0020;
    cyc();
    core_req = 1'b0; periph_gnt = 1'b1;
    cyc();
    periph_gnt = 1'b0;
    for (int i = 3; i <= 17; i++) begin
      cyc();
      chk("t3_wait", 32'(core_rvalid), 32'h0);
    end
    cyc();
    chk("t3_rvalid", 32'(core_rvalid), 32'h1);
    chk("t3_err",    32'(core_err),    32'h1);
    chk("t3_rdata",  core_rdata,       32'h0);
    cyc();
    chk("t3_regnt", 32'(core_gnt), 32'h1);

    // Next request accepted, then reset lands in WAIT_RVALID (T5)
    core_req = 1'b1; core_we = 1'b1; core_be = 4'h3;
    core_addr = 32'h0000_0030; core_wdata = 32'h0000_55AA;
    cyc();
    core_req = 1'b0; core_we = 1'b0;
    chk("t3_preq",   32'(periph_req), 32'h1);
    chk("t3_pwe",    32'(periph_we),  32'h1);
    chk("t3_pbe",    32'(periph_be),  32'h3);
    chk("t3_pwdata", periph_wdata,    32'h0000_55AA);
    periph_gnt = 1'b1;
    cyc();
    periph_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    cyc();
    rst = 1'b1;
    periph_rvalid = 1'b1; periph_rdata = 32'h0000_DEAD;
    cyc();
    periph_rvalid = 1'b0;
    chk("t5_no_rvalid", 32'(core_rvalid), 32'h0);
    chk("t5_gnt",       32'(core_gnt),    32'h1);
    chk("t5_preq",      32'(periph_req),  32'h0);
    cyc();
    chk("t5_no_rvalid2", 32'(core_rvalid), 32'h0);

    // T4: grant in the expiry cycle, plus a stray rvalid during WAIT_GNT
    core_req = 1'b1; core_addr = 32'h0000_0040;
    cyc();
    core_req = 1'b0;
    cyc();
    periph_rvalid = 1'b1;
    cyc();
    periph_rvalid = 1'b0;
    chk("t4_stray_preq",   32'(periph_req),  32'h1);
    chk("t4_stray_rvalid", 32'(core_rvalid), 32'h0);
    for (int i = 4; i <= 15; i++) cyc();
    cyc();
    periph_gnt = 1'b1;
    cyc();
    periph_gnt = 1'b0;
    chk("t4_no_tmo", 32'(core_rvalid), 32'h0);
    chk("t4_preq",   32'(periph_req),  32'h0);
    periph_rvalid = 1'b1; periph_rdata = 32'h1234_5678;
    cyc();
    periph_rvalid = 1'b0;
    chk("t4_rvalid", 32'(core_rvalid), 32'h1);
    chk("t4_err",    32'(core_err),    32'h0);
    chk("t4_rdata",  core_rdata,       32'h1234_5678);
    cyc();
    chk("t4_evalid", 32'(err_valid), 32'h0);

    // T6: err_clr in the same cycle as a new timeout
    core_req = 1'b1; core_addr = 32'h0BAD_0000;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      core_req = 1'b0;
    end
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t6_rvalid", 32'(core_rvalid), 32'h1);
    chk("t6_err",    32'(core_err),    32'h1);
`ifdef BUS_ERR_LOG_EN
    chk("t6_evalid", 32'(err_valid), 32'h1);
    chk("t6_eaddr",  err_addr,       32'h0BAD_0000);
`else
    chk("t6_evalid_off", 32'(err_valid), 32'h0);
    chk("t6_eaddr_off",  err_addr,       32'h0);
`endif
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
